imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
- Instruction-memory responder at the far end of the core's fetch interface: accepts PC fetch requests and returns 32-bit instructions after a fixed, parameterised latency.
- Also contains a byte-stream program loader that fills the memory little-endian while fetch is blocked.
- Sits between the program counter / fetch stage and the external program-load source.

Parameters:
- DEPTH, 256, instruction words stored; power of 2, ≥4.
- LATENCY, 1, cycles from request acceptance to response; legal range 1..4.
- NOP_INSTR, 32'h00000013, word returned on error responses.

Ports:
- clk  in  1  clock, rising edge.
- arst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  fetch request.
- req_addr  in  32  byte address of the instruction (PC value).
- req_ready  out  1  request can be accepted this cycle.
- rsp_valid  out  1  response valid, 1-cycle pulse per accepted request.
- rsp_instr  out  32  fetched instruction.
- rsp_err  out  1  qualifies rsp_valid: misaligned or out-of-range address.
- ld_en  in  1  load mode; blocks fetch while high.
- ld_byte_valid  in  1  ld_byte is valid this cycle.
- ld_byte  in  8  program byte, little-endian stream.
- ld_done  out  1  1-cycle pulse when load mode ends.
- ld_overflow  out  1  sticky: bytes arrived after memory was full.
- busy  out  1  fetch pipeline non-empty or load FSM not IDLE.

Behaviour:
- Reset (arst=0, asynchronous) sets every output to 0 except req_ready=1. It also clears the pipeline valid bits, the byte counter, the word pointer, the overflow flag, and returns the FSM to IDLE. Memory contents are not reset and are retained across reset.
- Fetch acceptance: a request is accepted when req_valid && req_ready. req_ready = (state==IDLE) && !ld_en. At most one request per cycle; full throughput.
- Memory is read in the acceptance cycle; read data is then delayed through LATENCY register stages.
  - rsp_valid is asserted exactly LATENCY cycles after acceptance, and responses come back in order.
  - There is no backpressure on the response side.
- Error: req_addr[1:0]!=0, or req_addr[31:2] >= DEPTH, gives rsp_err=1 and rsp_instr=NOP_INSTR with the same latency. Otherwise rsp_err=0 and rsp_instr=mem[req_addr[log2(DEPTH)+1:2]].
- When rsp_valid=0, rsp_instr holds its last value and rsp_err=0.
- Load FSM states: IDLE, COLLECT, WRITE.
  - IDLE→COLLECT on ld_en=1. This clears the byte counter, word pointer and ld_overflow.
  - COLLECT: each ld_byte_valid places ld_byte into byte lane [cnt] (cnt 0..3, lane 0 = bits 7:0) and increments cnt. On the 4th byte → WRITE.
  - WRITE (1 cycle): writes the word to mem[ptr] and increments ptr. Returns to COLLECT if ld_en=1, else to IDLE with ld_done pulsed.
  - COLLECT with ld_en=0: any partial word (cnt≠0) is discarded, ld_done pulses, and the FSM goes to IDLE.
  - A byte arriving during WRITE is ignored (source rule: at most 1 byte per 2 cycles across a word boundary). A bench must flag this as a protocol violation.
  - ptr == DEPTH: full. Further bytes are dropped and ld_overflow=1 (sticky until next IDLE→COLLECT). ptr does not wrap.
- Simultaneous events:
  - ld_en rising while fetches are in flight: the pipeline drains normally with data read at acceptance. New requests are blocked the same cycle.
  - ld_en and req_valid rising together: the request is not accepted.
- busy = any pipeline stage valid || state≠IDLE.
- Reset mid-load: the FSM aborts, a partial word is lost, and ld_done is not pulsed. Words already written remain in memory.
- Reset mid-fetch: in-flight responses are dropped, with no rsp_valid.

Decomposition:
- Shared package holds:
  - the load FSM state enum (IDLE/COLLECT/WRITE);
  - the NOP_INSTR constant (RV32I addi x0,x0,0);
  - an address-index width function clog2(DEPTH).
- One sub-module, imem_resp_pipe: LATENCY-deep valid/data/err shift pipeline with async reset on the valid bits only.
- The memory array and load FSM stay in the top level.

Test Plan:
- Load bytes 13 00 00 00 93 00 10 00, then drop ld_en → ld_done pulses once; fetch addr 0 → rsp_instr=32'h00000013; addr 4 → 32'h00100093, each LATENCY cycles after acceptance.
- Back-to-back fetches addr 0,4,0 on consecutive cycles with LATENCY=3 → three consecutive rsp_valid pulses, in order, starting at cycle 3.
- Fetch addr 32'h2 → rsp_err=1, rsp_instr=32'h00000013. Fetch addr 4*DEPTH → rsp_err=1.
- Load 6 bytes, then drop ld_en → only word 0 written; word 1 retains its old value; ld_done pulses once.
- DEPTH=4: stream 20 bytes → words 0..3 written; ld_overflow=1 after byte 17. Next ld_en rise clears it.
- Assert arst mid-COLLECT and with 2 fetches in flight → no rsp_valid, no ld_done; after release req_ready=1. Earlier-loaded words are still readable.

Source files
------------

// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: load FSM
// state encoding, the canonical NOP word and an index-width helper.
package imem_responder_pkg;

    typedef logic [1:0] ld_state_t;

    localparam ld_state_t ST_IDLE    = 2'd0;
    localparam ld_state_t ST_COLLECT = 2'd1;
    localparam ld_state_t ST_WRITE   = 2'd2;

    // RV32I addi x0,x0,0
    localparam logic [31:0] NOP_RV32I = 32'h0000_0013;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/imem_resp_pipe.sv
// Fixed-latency response pipeline carrying read data and the error flag
// from the acceptance cycle to the response cycle.
module imem_resp_pipe #(
    parameter int LATENCY = 1,
    parameter int WIDTH   = 32
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_err,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic             active
);

    logic [LATENCY-1:0] valid_q;
    logic [WIDTH-1:0]   data_q [LATENCY];
    logic [LATENCY-1:0] err_q;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= in_valid;
            for (int i = 1; i < LATENCY; i++) valid_q[i] <= valid_q[i-1];
        end
    end

    // NOTE: payload registers carry no reset; only the valid bits need a
    // known state, and moving payload behind its valid bit keeps the last
    // stage holding the most recent response.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            data_q[0] <= in_data;
            err_q[0]  <= in_err;
        end
        for (int i = 1; i < LATENCY; i++) begin
            if (valid_q[i-1]) begin
                data_q[i] <= data_q[i-1];
                err_q[i]  <= err_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];
    assign out_err   = err_q[LATENCY-1];
    assign active    = |valid_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency fetch port plus a
// little-endian byte-stream loader that owns the memory while ld_en is high.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter int          LATENCY   = 1,
    parameter logic [31:0] NOP_INSTR = NOP_RV32I
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_instr,
    output logic        rsp_err,
    input  logic        ld_en,
    input  logic        ld_byte_valid,
    input  logic [7:0]  ld_byte,
    output logic        ld_done,
    output logic        ld_overflow,
    output logic        busy
);

    localparam int              AW       = clog2(DEPTH);
    localparam logic [29:0]     MAX_WORD = 30'(DEPTH);
    localparam logic [AW:0]     FULL_PTR = (AW+1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    ld_state_t     state;
    logic [1:0]    cnt;
    logic [AW:0]   ptr;
    logic [31:0]   word;
    logic          full;
    logic          take_byte;

    logic          accept;
    logic          addr_err;
    logic [AW-1:0] idx;
    logic [31:0]   rd_data;
    logic          pipe_valid;
    logic [31:0]   pipe_data;
    logic          pipe_err;
    logic          pipe_active;
    logic          seen;

    // ---------------- fetch side ----------------
    assign req_ready = (state == ST_IDLE) && !ld_en;
    assign accept    = req_valid && req_ready;
    assign idx       = req_addr[AW+1:2];
    assign addr_err  = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= MAX_WORD);
    assign rd_data   = addr_err ? NOP_INSTR : mem[idx];

    imem_resp_pipe #(
        .LATENCY (LATENCY),
        .WIDTH   (32)
    ) u_pipe (
        .clk       (clk),
        .arst      (arst),
        .in_valid  (accept),
        .in_data   (rd_data),
        .in_err    (addr_err),
        .out_valid (pipe_valid),
        .out_data  (pipe_data),
        .out_err   (pipe_err),
        .active    (pipe_active)
    );

    // rsp_instr reads zero until the first response after reset, then holds.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst)           seen <= 1'b0;
        else if (pipe_valid) seen <= 1'b1;
    end

    assign rsp_valid = pipe_valid;
    assign rsp_err   = pipe_valid && pipe_err;
    assign rsp_instr = (pipe_valid || seen) ? pipe_data : 32'h0;
    assign busy      = pipe_active || (state != ST_IDLE);

    // ---------------- loader ----------------
    assign full      = (ptr == FULL_PTR);
    assign take_byte = (state == ST_COLLECT) && ld_en && ld_byte_valid && !full;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            ptr         <= '0;
            ld_overflow <= 1'b0;
            ld_done     <= 1'b0;
        end else begin
            ld_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ld_en) begin
                        state       <= ST_COLLECT;
                        cnt         <= '0;
                        ptr         <= '0;
                        ld_overflow <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    if (!ld_en) begin
                        state   <= ST_IDLE;
                        cnt     <= '0;
                        ld_done <= 1'b1;
                    end else if (ld_byte_valid) begin
                        if (full) begin
                            ld_overflow <= 1'b1;
                        end else begin
                            cnt <= cnt + 2'd1;
                            if (cnt == 2'd3) state <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    ptr <= ptr + 1'b1;
                    if (ld_en) begin
                        state <= ST_COLLECT;
                    end else begin
                        state   <= ST_IDLE;
                        ld_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (take_byte) word[{cnt, 3'b000} +: 8] <= ld_byte;
    end

    // Memory has no reset so a loaded program survives a core reset.
    always_ff @(posedge clk) begin
        if (state == ST_WRITE) mem[ptr[AW-1:0]] <= word;
    end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three instances (LATENCY 1/3/2, DEPTH 256/256/4)
// checked every cycle against a queue-based response model.
module tb_imem_responder;

    logic        clk = 1'b0;
    logic        arst;
    logic        req_valid [3];
    logic [31:0] req_addr [3];
    logic        req_ready [3];
    logic        rsp_valid [3];
    logic [31:0] rsp_instr [3];
    logic        rsp_err [3];
    logic        ld_en [3];
    logic        ld_byte_valid [3];
    logic [7:0]  ld_byte [3];
    logic        ld_done [3];
    logic        ld_overflow [3];
    logic        busy [3];

    always #5 clk = ~clk;

    imem_responder #(.DEPTH(256), .LATENCY(1)) u_dut0 (
        .clk(clk), .arst(arst), .req_valid(req_valid[0]), .req_addr(req_addr[0]),
        .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]), .rsp_instr(rsp_instr[0]),
        .rsp_err(rsp_err[0]), .ld_en(ld_en[0]), .ld_byte_valid(ld_byte_valid[0]),
        .ld_byte(ld_byte[0]), .ld_done(ld_done[0]), .ld_overflow(ld_overflow[0]), .busy(busy[0]));

    imem_responder #(.DEPTH(256), .LATENCY(3)) u_dut1 (
        .clk(clk), .arst(arst), .req_valid(req_valid[1]), .req_addr(req_addr[1]),
        .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]), .rsp_instr(rsp_instr[1]),
        .rsp_err(rsp_err[1]), .ld_en(ld_en[1]), .ld_byte_valid(ld_byte_valid[1]),
        .ld_byte(ld_byte[1]), .ld_done(ld_done[1]), .ld_overflow(ld_overflow[1]), .busy(busy[1]));

    imem_responder #(.DEPTH(4), .LATENCY(2)) u_dut2 (
        .clk(clk), .arst(arst), .req_valid(req_valid[2]), .req_addr(req_addr[2]),
        .req_ready(req_ready[2]), .rsp_valid(rsp_valid[2]), .rsp_instr(rsp_instr[2]),
        .rsp_err(rsp_err[2]), .ld_en(ld_en[2]), .ld_byte_valid(ld_byte_valid[2]),
        .ld_byte(ld_byte[2]), .ld_done(ld_done[2]), .ld_overflow(ld_overflow[2]), .busy(busy[2]));

    typedef struct {
        int          d;
        int          due;
        logic [31:0] instr;
        logic        err;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        exp_q [$];
    logic [7:0]  ld_q [$];
    logic [31:0] mm [3][256];
    logic [31:0] last_instr [3];
    int          done_cnt [3];
    int          rsp_cnt [3];
    int          last_rsp_cyc [3];
    logic [31:0] last_rsp_instr [3];
    logic        last_rsp_err [3];
    logic        prev_byte [3];

    function automatic int dep(int d);
        return (d == 2) ? 4 : 256;
    endfunction

    function automatic int lat(int d);
        return (d == 0) ? 1 : (d == 1) ? 3 : 2;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected response for a request driven this cycle.
    task automatic push(int d, logic [31:0] a);
        exp_t e;
        e.d     = d;
        e.due   = cyc + lat(d);
        e.err   = (a[1:0] != 2'b00) || ((a >> 2) >= 32'(dep(d)));
        e.instr = e.err ? 32'h0000_0013 : mm[d][a[9:2]];
        exp_q.push_back(e);
    endtask

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            int idx;
            if (!arst) begin
                check($sformatf("reset_outputs%0d", d),
                      {rsp_valid[d], rsp_err[d], ld_done[d], ld_overflow[d], busy[d], req_ready[d], rsp_instr[d]},
                      {5'b00000, 1'b1, 32'h0});
                last_instr[d] = 32'h0;
            end else begin
                idx = -1;
                foreach (exp_q[k]) if (exp_q[k].d == d && exp_q[k].due == cyc) idx = k;
                if (idx >= 0) begin
                    check($sformatf("rsp%0d_c%0d", d, cyc), {rsp_valid[d], rsp_err[d], rsp_instr[d]},
                          {1'b1, exp_q[idx].err, exp_q[idx].instr});
                    last_instr[d] = exp_q[idx].instr;
                    exp_q.delete(idx);
                end else begin
                    check($sformatf("idle%0d_c%0d", d, cyc), {rsp_valid[d], rsp_err[d], rsp_instr[d]},
                          {1'b0, 1'b0, last_instr[d]});
                end
            end
            if (rsp_valid[d]) begin
                rsp_cnt[d]++;
                last_rsp_cyc[d]   = cyc;
                last_rsp_instr[d] = rsp_instr[d];
                last_rsp_err[d]   = rsp_err[d];
            end
            if (ld_done[d]) done_cnt[d]++;
            if (ld_byte_valid[d] && prev_byte[d]) begin
                errors++;
                $display("FAIL protocol%0d: byte on consecutive cycles at %0d", d, cyc);
            end
            prev_byte[d] = ld_byte_valid[d];
        end
    end

    task automatic fetch(int d, logic [31:0] a);
        check($sformatf("ready%0d_%0h", d, a), req_ready[d], 1'b1);
        req_valid[d] = 1'b1;
        req_addr[d]  = a;
        push(d, a);
        tick();
        req_valid[d] = 1'b0;
        repeat (lat(d) + 1) tick();
    endtask

    // Streams ld_q into instance d (one byte every other cycle), then drops ld_en.
    task automatic load(int d, bit with_req);
        int n;
        int d0;
        int nw;
        n = ld_q.size();
        ld_en[d] = 1'b1;
        if (with_req) begin
            req_valid[d] = 1'b1;
            req_addr[d]  = 32'h0;
        end
        tick();
        req_valid[d] = 1'b0;
        @(negedge clk);
        check($sformatf("ld_block%0d", d), req_ready[d], 1'b0);
        check($sformatf("ld_ovf_clear%0d", d), ld_overflow[d], 1'b0);
        tick();
        for (int i = 0; i < n; i++) begin
            ld_byte_valid[d] = 1'b1;
            ld_byte[d]       = ld_q[i];
            tick();
            ld_byte_valid[d] = 1'b0;
            @(negedge clk);
            check($sformatf("ovf%0d_b%0d", d, i + 1), ld_overflow[d], (i + 1) > 4 * dep(d));
            tick();
        end
        d0 = done_cnt[d];
        ld_en[d] = 1'b0;
        repeat (4) tick();
        check($sformatf("ld_done_once%0d", d), done_cnt[d] - d0, 1);
        check($sformatf("ld_end_state%0d", d), {busy[d], req_ready[d], ld_overflow[d]},
              {1'b0, 1'b1, n > 4 * dep(d)});
        nw = n / 4;
        if (nw > dep(d)) nw = dep(d);
        for (int k = 0; k < nw; k++)
            mm[d][k] = {ld_q[4*k+3], ld_q[4*k+2], ld_q[4*k+1], ld_q[4*k]};
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        int r0;
        int d0;
        arst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            req_valid[d] = 1'b0; req_addr[d] = 32'h0; ld_en[d] = 1'b0;
            ld_byte_valid[d] = 1'b0; ld_byte[d] = 8'h0;
            last_instr[d] = 32'h0; done_cnt[d] = 0; rsp_cnt[d] = 0;
            last_rsp_cyc[d] = 0; last_rsp_instr[d] = 32'h0; last_rsp_err[d] = 1'b0;
            prev_byte[d] = 1'b0;
        end
        repeat (3) tick();
        arst = 1'b1;
        tick();

        // Two-word program into the LATENCY 1 and LATENCY 3 instances.
        ld_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        load(0, 1'b0);
        load(1, 1'b0);
        fetch(0, 32'h0);
        check("word0_literal", last_rsp_instr[0], 32'h0000_0013);
        fetch(0, 32'h4);
        check("word1_literal", last_rsp_instr[0], 32'h0010_0093);

        // Back-to-back on LATENCY 3.
        c0 = cyc;
        r0 = rsp_cnt[1];
        req_valid[1] = 1'b1;
        req_addr[1] = 32'h0; push(1, 32'h0); tick();
        req_addr[1] = 32'h4; push(1, 32'h4); tick();
        req_addr[1] = 32'h0; push(1, 32'h0); tick();
        req_valid[1] = 1'b0;
        repeat (5) tick();
        check("b2b_count", rsp_cnt[1] - r0, 3);
        check("b2b_last_cycle", last_rsp_cyc[1] - c0, 5);

        // Address errors.
        fetch(0, 32'h2);
        check("misaligned_err", {last_rsp_err[0], last_rsp_instr[0]}, {1'b1, 32'h0000_0013});
        fetch(0, 32'd1024);
        check("range_err", last_rsp_err[0], 1'b1);
        fetch(0, 32'hFFFF_FFFC);
        fetch(2, 32'd16);
        check("range_err_d4", last_rsp_err[2], 1'b1);

        // Partial load with a request colliding with ld_en rise.
        ld_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        load(0, 1'b1);
        fetch(0, 32'h0);
        check("partial_word0", last_rsp_instr[0], 32'hDDCC_BBAA);
        fetch(0, 32'h4);
        check("partial_word1_kept", last_rsp_instr[0], 32'h0010_0093);

        // ld_en rising with a fetch in flight: it drains, the blocked request is dropped.
        r0 = rsp_cnt[1];
        d0 = done_cnt[1];
        req_valid[1] = 1'b1; req_addr[1] = 32'h4; push(1, 32'h4); tick();
        ld_en[1] = 1'b1; tick();
        req_valid[1] = 1'b0; ld_en[1] = 1'b0;
        repeat (5) tick();
        check("drain_count", rsp_cnt[1] - r0, 1);
        check("drain_done", done_cnt[1] - d0, 1);

        // Overflow on DEPTH 4: 20 bytes, words 0..3 written.
        ld_q.delete();
        for (int i = 0; i < 20; i++) ld_q.push_back(8'(i + 1));
        load(2, 1'b0);
        fetch(2, 32'd12);
        check("d4_word3", last_rsp_instr[2], 32'h100F_0E0D);
        fetch(2, 32'd0);
        check("d4_word0", last_rsp_instr[2], 32'h0403_0201);
        ld_q = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
        load(2, 1'b0);
        fetch(2, 32'd0);
        check("d4_reload", last_rsp_instr[2], 32'hC33C_A55A);

        // Reset mid-COLLECT on instance 0 with two fetches in flight on instance 1.
        d0 = done_cnt[0];
        r0 = rsp_cnt[1];
        ld_en[0] = 1'b1;
        req_valid[1] = 1'b1; req_addr[1] = 32'h0; push(1, 32'h0); tick();
        ld_byte_valid[0] = 1'b1; ld_byte[0] = 8'h11;
        req_addr[1] = 32'h4; push(1, 32'h4); tick();
        ld_byte_valid[0] = 1'b0; ld_en[0] = 1'b0; req_valid[1] = 1'b0;
        arst = 1'b0;
        exp_q.delete();
        repeat (4) tick();
        arst = 1'b1;
        repeat (2) tick();
        check("rst_no_done", done_cnt[0] - d0, 0);
        check("rst_no_rsp", rsp_cnt[1] - r0, 0);
        check("rst_ready", {req_ready[0], req_ready[1], req_ready[2]}, 3'b111);
        fetch(0, 32'h0);
        check("rst_word0_kept", last_rsp_instr[0], 32'hDDCC_BBAA);
        fetch(1, 32'h4);
        check("rst_word1_kept", last_rsp_instr[1], 32'h0010_0093);
        check("exp_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
